// File: rtl/jk_onoff_bank.sv
// jk_onoff_bank: bank of NCH independent ON/OFF Moore controllers.
// Each channel turns on with j and off with k. The j&k=1 case is resolved by
// MODE: toggle, set-dominant or reset-dominant. After a transition the channel
// optionally ignores j/k for MIN_DWELL edges. force_off drives every channel
// OFF and clears any dwell in progress. The block also reports a one-cycle
// change strobe per channel and the number of channels that are ON.
//
// Handshake: there is none. j, k and force_off are level requests that are
// sampled on every rising clk edge. out, chg and on_cnt are all registered and
// all update on that same edge.
module jk_onoff_bank #(
  parameter int NCH       = 4,
  parameter int MODE      = 0,
  parameter int MIN_DWELL = 2,
  parameter int DW_W      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCH-1:0]           j,
  input  logic [NCH-1:0]           k,
  input  logic                     force_off,
  output logic [NCH-1:0]           out,
  output logic [NCH-1:0]           chg,
  output logic [$clog2(NCH+1)-1:0] on_cnt,
  output logic [2*NCH-1:0]         state_dbg
);

  localparam int CW = $clog2(NCH+1);
  localparam logic [DW_W-1:0] DWELL_LD = DW_W'(MIN_DWELL);
  localparam bit USE_DWELL = (MIN_DWELL > 0);
  // MODE values other than 1 and 2 fall back to toggle behaviour.
  localparam bit JK_SET = (MODE == 1);
  localparam bit JK_RST = (MODE == 2);

  // state_dbg packs one 2-bit code per channel, channel 0 in the low bits.
  typedef enum logic [1:0] {
    S_OFF      = 2'd0,
    S_ON       = 2'd1,
    S_OFF_HOLD = 2'd2,
    S_ON_HOLD  = 2'd3
  } ch_state_t;

  logic [NCH-1:0] out_d;
  logic [CW-1:0]  on_cnt_d;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    ch_state_t       st_q, st_d;
    logic [DW_W-1:0] cnt_q, cnt_d;
    logic            take_on, take_off;

    // Decode j/k into on/off requests. The j&k=1 resolution is folded in here.
    always_comb begin
      take_on  = j[g] & (~k[g] | ~JK_RST);
      take_off = k[g] & (~j[g] | ~JK_SET);
    end

    // Next state. A HOLD state counts down and returns to its base state on the
    // edge where the counter would reach zero. A no-change outcome does not
    // reload the dwell counter.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      case (st_q)
        S_OFF: begin
          if (take_on) begin
            st_d  = USE_DWELL ? S_ON_HOLD : S_ON;
            cnt_d = DWELL_LD;
          end
        end
        S_ON: begin
          if (take_off) begin
            st_d  = USE_DWELL ? S_OFF_HOLD : S_OFF;
            cnt_d = DWELL_LD;
          end
        end
        S_OFF_HOLD: begin
          if (cnt_q > DW_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = '0;
            st_d  = S_OFF;
          end
        end
        S_ON_HOLD: begin
          if (cnt_q > DW_W'(1)) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            cnt_d = '0;
            st_d  = S_ON;
          end
        end
        default: begin
          st_d  = S_OFF;
          cnt_d = '0;
        end
      endcase
      // force_off overrides j/k, MODE and dwell, and it does not start a dwell.
      if (force_off) begin
        st_d  = S_OFF;
        cnt_d = '0;
      end
    end

    // Channel state and dwell counter registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= S_OFF;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    assign out_d[g]           = (st_d == S_ON) || (st_d == S_ON_HOLD);
    assign state_dbg[2*g +: 2] = st_q;
  end

  // Population count of the next output vector, so on_cnt never lags out.
  always_comb begin
    on_cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      on_cnt_d = on_cnt_d + CW'(out_d[i]);
    end
  end

  // Registered outputs. chg compares the next output with the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      out    <= '0;
      chg    <= '0;
      on_cnt <= '0;
    end else begin
      out    <= out_d;
      chg    <= out_d ^ out;
      on_cnt <= on_cnt_d;
    end
  end

endmodule

// File: tb/tb_jk_onoff_bank.sv
// Directed bench for jk_onoff_bank. Four instances share the same stimulus:
//   a: MODE0, no dwell     b: MODE1, no dwell
//   c: MODE2, no dwell     d: MODE0, MIN_DWELL=2
// Each scenario starts from a reset. Only the instances the scenario targets
// are compared.
module tb_jk_onoff_bank;

  logic       clk;
  logic       reset;
  logic [3:0] j;
  logic [3:0] k;
  logic       force_off;

  logic [3:0] out_a, chg_a, out_b, chg_b, out_c, chg_c, out_d, chg_d;
  logic [2:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic [7:0] dbg_a, dbg_b, dbg_c, dbg_d;

  int n_checks;
  int n_pass;

  jk_onoff_bank #(.NCH(4), .MODE(0), .MIN_DWELL(0), .DW_W(4)) dut_a (
    .clk(clk), .reset(reset), .j(j), .k(k), .force_off(force_off),
    .out(out_a), .chg(chg_a), .on_cnt(cnt_a), .state_dbg(dbg_a));
  jk_onoff_bank #(.NCH(4), .MODE(1), .MIN_DWELL(0), .DW_W(4)) dut_b (
    .clk(clk), .reset(reset), .j(j), .k(k), .force_off(force_off),
    .out(out_b), .chg(chg_b), .on_cnt(cnt_b), .state_dbg(dbg_b));
  jk_onoff_bank #(.NCH(4), .MODE(2), .MIN_DWELL(0), .DW_W(4)) dut_c (
    .clk(clk), .reset(reset), .j(j), .k(k), .force_off(force_off),
    .out(out_c), .chg(chg_c), .on_cnt(cnt_c), .state_dbg(dbg_c));
  jk_onoff_bank #(.NCH(4), .MODE(0), .MIN_DWELL(2), .DW_W(4)) dut_d (
    .clk(clk), .reset(reset), .j(j), .k(k), .force_off(force_off),
    .out(out_d), .chg(chg_d), .on_cnt(cnt_d), .state_dbg(dbg_d));

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    j = 4'b0000; k = 4'b0000; force_off = 1'b0;
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    // Reset for two edges, then idle for five.
    reset = 1'b1; j = 4'b0000; k = 4'b0000; force_off = 1'b0;
    step();
    step();
    check("rst_out_a", out_a, 4'b0000);
    check("rst_cnt_a", {1'b0, cnt_a}, 4'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_out_a", out_a, 4'b0000);
      check("idle_chg_a", chg_a, 4'b0000);
      check("idle_cnt_a", {1'b0, cnt_a}, 4'd0);
      check("idle_out_d", out_d, 4'b0000);
    end

    // Basic set/clear with no dwell.
    j = 4'b0101;
    step();
    check("set_out_a", out_a, 4'b0101);
    check("set_chg_a", chg_a, 4'b0101);
    check("set_cnt_a", {1'b0, cnt_a}, 4'd2);
    j = 4'b0000;
    step();
    check("hold_out_a", out_a, 4'b0101);
    check("hold_chg_a", chg_a, 4'b0000);
    check("hold_cnt_a", {1'b0, cnt_a}, 4'd2);
    k = 4'b0001;
    step();
    check("clr_out_a", out_a, 4'b0100);
    check("clr_chg_a", chg_a, 4'b0001);
    check("clr_cnt_a", {1'b0, cnt_a}, 4'd1);
    k = 4'b0000;
    step();
    check("clr2_chg_a", chg_a, 4'b0000);

    // Dwell of two: k is ignored on the two edges after the turn-on.
    do_reset();
    j = 4'b0001;
    step();
    check("dw_on_out_d", out_d, 4'b0001);
    check("dw_on_chg_d", chg_d, 4'b0001);
    j = 4'b0000; k = 4'b0001;
    step();
    check("dw_t1_out_d", out_d, 4'b0001);
    check("dw_t1_chg_d", chg_d, 4'b0000);
    step();
    check("dw_t2_out_d", out_d, 4'b0001);
    step();
    check("dw_t3_out_d", out_d, 4'b0000);
    check("dw_t3_chg_d", chg_d, 4'b0001);
    check("dw_t3_cnt_d", {1'b0, cnt_d}, 4'd0);
    step();
    check("dw_t4_out_d", out_d, 4'b0000);
    check("dw_t4_chg_d", chg_d, 4'b0000);
    k = 4'b0000;

    // j=k=1 held for three edges under each conflict mode.
    do_reset();
    j = 4'b1111; k = 4'b1111;
    step();
    check("jk1_out_a", out_a, 4'b1111);
    check("jk1_out_b", out_b, 4'b1111);
    check("jk1_out_c", out_c, 4'b0000);
    check("jk1_cnt_a", {1'b0, cnt_a}, 4'd4);
    step();
    check("jk2_out_a", out_a, 4'b0000);
    check("jk2_chg_a", chg_a, 4'b1111);
    check("jk2_out_b", out_b, 4'b1111);
    check("jk2_chg_b", chg_b, 4'b0000);
    check("jk2_out_c", out_c, 4'b0000);
    check("jk2_cnt_a", {1'b0, cnt_a}, 4'd0);
    step();
    check("jk3_out_a", out_a, 4'b1111);
    check("jk3_out_b", out_b, 4'b1111);
    check("jk3_out_c", out_c, 4'b0000);
    check("jk3_chg_c", chg_c, 4'b0000);
    j = 4'b0000; k = 4'b0000;

    // force_off during a dwell, then immediate turn-on afterwards.
    do_reset();
    j = 4'b1111;
    step();
    check("fo_pre_out_d", out_d, 4'b1111);
    check("fo_pre_cnt_d", {1'b0, cnt_d}, 4'd4);
    j = 4'b0000; force_off = 1'b1;
    step();
    check("fo_out_d", out_d, 4'b0000);
    check("fo_chg_d", chg_d, 4'b1111);
    check("fo_cnt_d", {1'b0, cnt_d}, 4'd0);
    force_off = 1'b0; j = 4'b1111;
    step();
    check("fo_re_out_d", out_d, 4'b1111);
    check("fo_re_chg_d", chg_d, 4'b1111);
    check("fo_re_cnt_d", {1'b0, cnt_d}, 4'd4);
    force_off = 1'b1;
    step();
    check("fo_h1_out_d", out_d, 4'b0000);
    check("fo_h1_chg_d", chg_d, 4'b1111);
    step();
    check("fo_h2_out_d", out_d, 4'b0000);
    check("fo_h2_chg_d", chg_d, 4'b0000);
    force_off = 1'b0; j = 4'b0000;

    // Reset in the middle of a dwell while j is still high.
    do_reset();
    j = 4'b0001;
    step();
    check("rh_on_out_d", out_d, 4'b0001);
    reset = 1'b1;
    step();
    check("rh_out_d", out_d, 4'b0000);
    check("rh_chg_d", chg_d, 4'b0000);
    check("rh_cnt_d", {1'b0, cnt_d}, 4'd0);
    reset = 1'b0;
    step();
    check("rh_fresh_out_d", out_d, 4'b0001);
    check("rh_fresh_chg_d", chg_d, 4'b0001);
    j = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
